// File: rtl/fact_pkg.sv
// Shared state encoding, default limits and a constant-width helper for the
// round-robin factorial scheduler.
package fact_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_LAUNCH,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int DEF_MAX_N   = 12;
    localparam int DEF_TIMEOUT = 64;

    // Ceiling log2; usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester after last_grant wins,
// wrapping around, with last_grant itself considered last.
module rr_arbiter
    import fact_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_grant_i,
    output logic             valid_o,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  id_o
);

    logic [ID_W-1:0] idx;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        valid_o = 1'b0;
        grant_o = '0;
        id_o    = '0;
        idx     = '0;
        for (int s = 1; s <= N_REQ; s++) begin
            idx = ID_W'((int'(last_grant_i) + s) % N_REQ);
            if (!valid_o && req_i[idx]) begin
                valid_o      = 1'b1;
                grant_o[idx] = 1'b1;
                id_o         = idx;
            end
        end
    end

endmodule

// File: rtl/fact_sched.sv
// Round-robin scheduler sharing one go/done factorial unit between N_REQ
// requesters: arbitrate, range-check, launch, watchdog, and return a tagged response.
module fact_sched
    import fact_pkg::*;
#(
    parameter int  N_REQ   = 2,
    parameter int  N_W     = 4,
    parameter int  RES_W   = 32,
    parameter int  MAX_N   = DEF_MAX_N,
    parameter int  TIMEOUT = DEF_TIMEOUT,
    localparam int ID_W    = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*N_W-1:0] req_n,
    output logic [N_REQ-1:0]     ack,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [RES_W-1:0]     rsp_result,
    output logic                 rsp_err,
    output logic                 fact_go,
    output logic [N_W-1:0]       fact_n,
    output logic                 fact_clr,
    input  logic                 fact_done,
    input  logic [RES_W-1:0]     fact_result
);

    localparam int TMR_W = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [RES_W-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_err_q, rsp_err_d;
    logic               fact_go_q, fact_go_d;
    logic               fact_clr_q, fact_clr_d;

    logic               arb_valid;
    logic [N_REQ-1:0]   arb_grant;
    logic [ID_W-1:0]    arb_id;
    logic               n_bad;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .valid_o      (arb_valid),
        .grant_o      (arb_grant),
        .id_o         (arb_id)
    );

    assign n_bad = 32'(n_q) > 32'(MAX_N);

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        n_d          = n_q;
        timer_d      = timer_q;
        last_grant_d = last_grant_q;
        ack_d        = '0;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = '0;
        rsp_result_d = '0;
        rsp_err_d    = 1'b0;
        fact_go_d    = 1'b0;
        fact_clr_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    id_d    = arb_id;
                    n_d     = req_n[int'(arb_id)*N_W +: N_W];
                    ack_d   = arb_grant;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (n_bad) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    fact_go_d = 1'b1;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                timer_d = TMR_W'(TIMEOUT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the last timer cycle still counts as success.
                if (fact_done) begin
                    rsp_valid_d  = 1'b1;
                    rsp_id_d     = id_q;
                    rsp_result_d = fact_result;
                    state_d      = ST_RESP;
                end else if (timer_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_err_d   = 1'b1;
                    fact_clr_d  = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_RESP: begin
                last_grant_d = id_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            id_q         <= '0;
            n_q          <= '0;
            timer_q      <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            ack_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            fact_go_q    <= 1'b0;
            fact_clr_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            n_q          <= n_d;
            timer_q      <= timer_d;
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            fact_go_q    <= fact_go_d;
            fact_clr_q   <= fact_clr_d;
        end
    end

    assign ack        = ack_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign fact_go    = fact_go_q;
    assign fact_n     = n_q;
    assign fact_clr   = fact_clr_q;

endmodule

// File: tb/tb_fact_sched.sv
// Bench for fact_sched: models the factorial unit with programmable latency and
// checks each scenario against factorial arithmetic and round-robin ordering.
module tb_fact_sched;

    localparam int N_REQ   = 2;
    localparam int N_W     = 4;
    localparam int RES_W   = 32;
    localparam int MAX_N   = 12;
    localparam int TIMEOUT = 64;
    localparam int ID_W    = $clog2(N_REQ);

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [N_REQ-1:0]     req = '0;
    logic [N_REQ*N_W-1:0] req_n = '0;
    logic [N_REQ-1:0]     ack;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [RES_W-1:0]     rsp_result;
    logic                 rsp_err;
    logic                 fact_go;
    logic [N_W-1:0]       fact_n;
    logic                 fact_clr;
    logic                 fact_done;
    logic [RES_W-1:0]     fact_result;

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int model_last = N_REQ - 1;

    fact_sched #(
        .N_REQ   (N_REQ),
        .N_W     (N_W),
        .RES_W   (RES_W),
        .MAX_N   (MAX_N),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_n       (req_n),
        .ack         (ack),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_err     (rsp_err),
        .fact_go     (fact_go),
        .fact_n      (fact_n),
        .fact_clr    (fact_clr),
        .fact_done   (fact_done),
        .fact_result (fact_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [RES_W-1:0] ref_fact(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 2; i <= n; i++) p = p * longint'(i);
        return p[RES_W-1:0];
    endfunction

    // First pending requester after 'last', wrapping; 'last' itself has lowest priority.
    function automatic int rr_pick(input logic [N_REQ-1:0] pend, input int last);
        for (int s = 1; s <= N_REQ; s++) begin
            if (pend[(last + s) % N_REQ]) return (last + s) % N_REQ;
        end
        return -1;
    endfunction

    function automatic int q_first(input int q[$]);
        return (q.size() > 0) ? q[0] : -999;
    endfunction

    function automatic int q_last(input int q[$]);
        return (q.size() > 0) ? q[q.size()-1] : -999;
    endfunction

    // Factorial unit model: done rises k cycles after the go cycle and stays high
    // until the next go, clr or reset.
    int               unit_k    = 8;
    bit               unit_hang = 1'b0;
    logic             unit_busy;
    int               unit_cnt;
    logic [N_W-1:0]   unit_op;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            unit_busy   <= 1'b0;
            unit_cnt    <= 0;
            unit_op     <= '0;
            fact_done   <= 1'b0;
            fact_result <= '0;
        end else if (fact_clr) begin
            unit_busy <= 1'b0;
            fact_done <= 1'b0;
        end else if (fact_go) begin
            fact_done <= 1'b0;
            unit_op   <= fact_n;
            if (unit_k == 1 && !unit_hang) begin
                fact_done   <= 1'b1;
                fact_result <= ref_fact(int'(fact_n));
            end else begin
                unit_busy <= 1'b1;
                unit_cnt  <= 1;
            end
        end else if (unit_busy && !unit_hang) begin
            if (unit_cnt >= unit_k - 1) begin
                fact_done   <= 1'b1;
                fact_result <= ref_fact(int'(unit_op));
                unit_busy   <= 1'b0;
            end else begin
                unit_cnt <= unit_cnt + 1;
            end
        end
    end

    typedef struct {
        int               cyc;
        int               id;
        logic [RES_W-1:0] res;
        logic             err;
        logic             clr;
    } rsp_t;

    rsp_t rsp_q[$];
    int   ack_cyc[$];
    int   ack_id[$];
    int   go_cyc[$];
    int   go_n[$];

    task automatic clear_logs();
        rsp_q.delete();
        ack_cyc.delete();
        ack_id.delete();
        go_cyc.delete();
        go_n.delete();
    endtask

    // One cycle at the falling edge: log DUT events, requesters drop req on ack.
    task automatic step();
        rsp_t r;
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++) begin
            if (ack[i]) begin
                req[i] = 1'b0;
                ack_cyc.push_back(cyc);
                ack_id.push_back(i);
            end
        end
        if (fact_go) begin
            go_cyc.push_back(cyc);
            go_n.push_back(int'(fact_n));
        end
        if (rsp_valid) begin
            r.cyc = cyc;
            r.id  = int'(rsp_id);
            r.res = rsp_result;
            r.err = rsp_err;
            r.clr = fact_clr;
            rsp_q.push_back(r);
        end
    endtask

    task automatic issue(input int id, input int n);
        req_n[id*N_W +: N_W] = N_W'(n);
        req[id] = 1'b1;
    endtask

    task automatic wait_rsp(input int budget, output bit got);
        for (int i = 0; i < budget && rsp_q.size() == 0; i++) step();
        got = (rsp_q.size() != 0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step();
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = '0;
        req_n = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ack, rsp_valid, rsp_id, rsp_result, rsp_err, fact_go, fact_n, fact_clr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0",
                     {ack, rsp_valid, rsp_id, rsp_result, rsp_err, fact_go, fact_n, fact_clr});
        end
        rst = 1'b1;
        model_last = N_REQ - 1;
        drain(3);
        n_checks++;
        if ({ack, rsp_valid, fact_go, fact_clr} !== '0) begin
            n_fail++;
            $display("FAIL idle_quiet: got %b want 0", {ack, rsp_valid, fact_go, fact_clr});
        end
    endtask

    task automatic test_single();
        int   t;
        bit   got;
        rsp_t r;
        clear_logs();
        unit_k = 8;
        unit_hang = 1'b0;
        t = cyc;
        issue(0, 5);
        wait_rsp(40, got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL single_rsp: no response within 40 cycles");
            return;
        end
        r = rsp_q.pop_front();
        n_checks++;
        if (q_first(ack_cyc) - t !== 1 || q_first(ack_id) !== 0) begin
            n_fail++;
            $display("FAIL single_ack: latency %0d id %0d, want latency 1 id 0",
                     q_first(ack_cyc) - t, q_first(ack_id));
        end
        n_checks++;
        if (q_first(go_cyc) - t !== 2 || q_first(go_n) !== 5) begin
            n_fail++;
            $display("FAIL single_go: latency %0d fact_n %0d, want latency 2 fact_n 5",
                     q_first(go_cyc) - t, q_first(go_n));
        end
        n_checks++;
        if (r.cyc - t !== 2 + 8 + 1) begin
            n_fail++;
            $display("FAIL single_rsp_time: latency %0d want %0d", r.cyc - t, 2 + 8 + 1);
        end
        n_checks++;
        if (r.id !== 0 || r.res !== 32'd120 || r.err !== 1'b0 || r.clr !== 1'b0) begin
            n_fail++;
            $display("FAIL single_payload: id %0d res %0d err %b clr %b, want 0 120 0 0",
                     r.id, r.res, r.err, r.clr);
        end
        model_last = 0;
        drain(2);
    endtask

    task automatic test_range();
        int   t;
        bit   got;
        rsp_t r;
        clear_logs();
        t = cyc;
        issue(1, 13);
        wait_rsp(20, got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL range_rsp: no response within 20 cycles");
            return;
        end
        r = rsp_q.pop_front();
        n_checks++;
        if (q_first(ack_cyc) - t !== 1 || q_first(ack_id) !== 1) begin
            n_fail++;
            $display("FAIL range_ack: latency %0d id %0d, want latency 1 id 1",
                     q_first(ack_cyc) - t, q_first(ack_id));
        end
        n_checks++;
        if (r.cyc - t !== 2 || r.id !== 1 || r.res !== '0 || r.err !== 1'b1 || r.clr !== 1'b0) begin
            n_fail++;
            $display("FAIL range_payload: lat %0d id %0d res %0d err %b clr %b, want 2 1 0 1 0",
                     r.cyc - t, r.id, r.res, r.err, r.clr);
        end
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (go_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL range_no_go: fact_go pulses %0d want 0", go_cyc.size());
        end
        model_last = 1;
        drain(1);
    endtask

    task automatic test_timeout();
        bit   got;
        rsp_t r;
        clear_logs();
        unit_hang = 1'b1;
        issue(0, 7);
        wait_rsp(TIMEOUT + 20, got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL timeout_rsp: no response within %0d cycles", TIMEOUT + 20);
            unit_hang = 1'b0;
            return;
        end
        r = rsp_q.pop_front();
        n_checks++;
        if (go_cyc.size() !== 1 || q_first(go_n) !== 7) begin
            n_fail++;
            $display("FAIL timeout_go: pulses %0d fact_n %0d, want 1 and 7", go_cyc.size(), q_first(go_n));
        end
        n_checks++;
        if (r.cyc - q_first(go_cyc) !== TIMEOUT + 1) begin
            n_fail++;
            $display("FAIL timeout_time: go-to-rsp %0d want %0d", r.cyc - q_first(go_cyc), TIMEOUT + 1);
        end
        n_checks++;
        if (r.id !== 0 || r.res !== '0 || r.err !== 1'b1 || r.clr !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_payload: id %0d res %0d err %b clr %b, want 0 0 1 1",
                     r.id, r.res, r.err, r.clr);
        end
        step();
        n_checks++;
        if (fact_clr !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clr_pulse: fact_clr %b one cycle after rsp, want 0", fact_clr);
        end
        unit_hang = 1'b0;
        model_last = 0;
        drain(1);
    endtask

    task automatic test_coincident();
        bit   got;
        rsp_t r;
        clear_logs();
        unit_k = TIMEOUT;
        issue(1, 10);
        wait_rsp(TIMEOUT + 20, got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL coincident_rsp: no response within %0d cycles", TIMEOUT + 20);
            return;
        end
        r = rsp_q.pop_front();
        n_checks++;
        if (r.cyc - q_first(go_cyc) !== TIMEOUT + 1) begin
            n_fail++;
            $display("FAIL coincident_time: go-to-rsp %0d want %0d", r.cyc - q_first(go_cyc), TIMEOUT + 1);
        end
        n_checks++;
        if (r.id !== 1 || r.res !== 32'd3628800 || r.err !== 1'b0 || r.clr !== 1'b0) begin
            n_fail++;
            $display("FAIL coincident_payload: id %0d res %0d err %b clr %b, want 1 3628800 0 0",
                     r.id, r.res, r.err, r.clr);
        end
        model_last = 1;
        drain(2);
    endtask

    task automatic test_rr();
        bit   got;
        rsp_t r;
        int   cur_n [N_REQ];
        int   exp_id;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_last = N_REQ - 1;
        drain(2);
        unit_k = 4;
        cur_n[0] = 3;
        cur_n[1] = 4;
        issue(0, cur_n[0]);
        issue(1, cur_n[1]);
        for (int j = 0; j < 6; j++) begin
            exp_id = j % 2;
            wait_rsp(40, got);
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL rr_rsp_%0d: no response within 40 cycles", j);
                break;
            end
            r = rsp_q.pop_front();
            if (r.id !== exp_id || r.res !== ref_fact(cur_n[exp_id]) || r.err !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_order_%0d: id %0d res %0d err %b, want %0d %0d 0",
                         j, r.id, r.res, r.err, exp_id, ref_fact(cur_n[exp_id]));
            end
            model_last = exp_id;
            if (j < 4) begin
                cur_n[exp_id] = int'($urandom_range(0, MAX_N));
                issue(exp_id, cur_n[exp_id]);
            end
            clear_logs();
        end
        drain(2);
    endtask

    task automatic test_random();
        bit               got;
        rsp_t             r;
        logic [N_REQ-1:0] pend;
        int               rn [N_REQ];
        int               exp_id;
        int               exp_lat;
        logic [RES_W-1:0] exp_res;
        logic             exp_err;
        for (int round = 0; round < 20; round++) begin
            unit_k = int'($urandom_range(1, 20));
            pend = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            clear_logs();
            for (int i = 0; i < N_REQ; i++) begin
                rn[i] = 0;
                if (pend[i]) begin
                    rn[i] = int'($urandom_range(0, 15));
                    issue(i, rn[i]);
                end
            end
            while (pend != '0) begin
                exp_id  = rr_pick(pend, model_last);
                exp_err = (rn[exp_id] > MAX_N);
                exp_res = exp_err ? '0 : ref_fact(rn[exp_id]);
                exp_lat = exp_err ? 1 : unit_k + 2;
                wait_rsp(60, got);
                n_checks++;
                if (!got) begin
                    n_fail++;
                    $display("FAIL rand_rsp_r%0d: no response within 60 cycles", round);
                    break;
                end
                r = rsp_q.pop_front();
                n_checks++;
                if (r.id !== exp_id || r.res !== exp_res || r.err !== exp_err || r.clr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_payload_r%0d: id %0d res %0d err %b clr %b, want %0d %0d %b 0",
                             round, r.id, r.res, r.err, r.clr, exp_id, exp_res, exp_err);
                end
                n_checks++;
                if (r.cyc - q_last(ack_cyc) !== exp_lat || q_last(ack_id) !== exp_id) begin
                    n_fail++;
                    $display("FAIL rand_timing_r%0d: ack-to-rsp %0d ack id %0d, want %0d id %0d",
                             round, r.cyc - q_last(ack_cyc), q_last(ack_id), exp_lat, exp_id);
                end
                pend[exp_id] = 1'b0;
                model_last = exp_id;
                clear_logs();
            end
            drain(2);
        end
    endtask

    task automatic test_reset_mid();
        int   t;
        bit   got;
        rsp_t r;
        clear_logs();
        unit_k = 30;
        issue(0, 6);
        for (int i = 0; i < 8 && go_cyc.size() == 0; i++) step();
        repeat (3) step();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({ack, rsp_valid, rsp_id, rsp_result, rsp_err, fact_go, fact_n, fact_clr} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %h want 0",
                     {ack, rsp_valid, rsp_id, rsp_result, rsp_err, fact_go, fact_n, fact_clr});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_last = N_REQ - 1;
        clear_logs();
        repeat (40) step();
        n_checks++;
        if (rsp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_rsp: %0d responses after abort, want 0", rsp_q.size());
        end
        clear_logs();
        unit_k = 3;
        t = cyc;
        issue(0, 0);
        wait_rsp(30, got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL midreset_rsp: no response within 30 cycles");
            return;
        end
        r = rsp_q.pop_front();
        n_checks++;
        if (r.cyc - t !== 2 + 3 + 1 || r.id !== 0 || r.res !== 32'd1 || r.err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_payload: lat %0d id %0d res %0d err %b, want 6 0 1 0",
                     r.cyc - t, r.id, r.res, r.err);
        end
        drain(2);
    endtask

    initial begin
        test_reset();
        test_single();
        test_range();
        test_timeout();
        test_coincident();
        test_rr();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
